// File: rtl/divider_host_pkg.sv
// Shared definitions for the divider host port: default parameters, FSM
// state encodings and the byte-count helper.
package divider_host_pkg;

    localparam int unsigned DEFAULT_WIDTH          = 16;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

    // FSM state encodings
    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] hostState_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND_REQ  = 3'd1;
    localparam logic [2:0] ST_SEND_GAP  = 3'd2;
    localparam logic [2:0] ST_WAIT_FULL = 3'd3;
    localparam logic [2:0] ST_RECV_REQ  = 3'd4;
    localparam logic [2:0] ST_RECV_GAP  = 3'd5;
    localparam logic [2:0] ST_RESP      = 3'd6;

    // Bytes moved in each direction: two operands in, two results out.
    function automatic int unsigned nBytes(input int unsigned width);
        return (2 * width) / 8;
    endfunction

endpackage

// File: rtl/divider_host_watchdog.sv
// Per-state watchdog for the divider host port.
// Ports: clk, reset (sync, active-high), clear (restart count),
//        enable (count this cycle), expired (registered; high once the
//        current state has been occupied for TIMEOUT_CYCLES cycles).
module divider_host_watchdog
    import divider_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;

    // Count saturates at LIMIT so a stuck state cannot wrap the watchdog.
    always_comb begin
        countNext = count;
        if (clear) begin
            countNext = '0;
        end else if (enable && (count != LIMIT)) begin
            countNext = count + CNT_W'(1);
        end
    end

    // expired is registered, so it lands on the edge the count reaches LIMIT
    // and the FSM acts on it one edge later: TIMEOUT_CYCLES cycles in state.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            count   <= countNext;
            expired <= enable && !clear && (countNext == LIMIT);
        end
    end

endmodule

// File: rtl/divider_host_port.sv
// Host-side initiator for the restoring divider's byte-serial interface.
// Ports: clk/reset (sync, active-high); req_valid/req_ready/dividend/divisor
//        request side; rsp_valid/rsp_ready/quotient/remainder/error response
//        side; StartData/DataIn/ReadyToAccept byte input handshake;
//        OutBuffFull/ReceiveData/Valid/DataOut result drain handshake.
module divider_host_port
    import divider_host_pkg::*;
#(
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             error,
    output logic             StartData,
    output logic [7:0]       DataIn,
    input  logic             ReadyToAccept,
    input  logic             OutBuffFull,
    output logic             ReceiveData,
    input  logic             Valid,
    input  logic [7:0]       DataOut
);

    localparam int unsigned NBYTES  = nBytes(WIDTH);
    localparam int unsigned CNT_W   = $clog2(NBYTES + 1);
    localparam int unsigned SHIFT_W = 2 * WIDTH;

    hostState_t       state, stateNext;
    logic [CNT_W-1:0] byteCount, byteCountNext;
    logic [SHIFT_W-1:0] txShift, txShiftNext;
    logic [SHIFT_W-1:0] rxShift, rxShiftNext;
    logic [7:0]       dataInNext;
    logic [WIDTH-1:0] quotientNext, remainderNext;
    logic             errorNext;
    logic             wdEnable, wdClear, wdExpired;

    // Watchdog runs only while waiting on the divider.
    assign wdEnable = (state == ST_SEND_REQ) || (state == ST_SEND_GAP) ||
                      (state == ST_WAIT_FULL) || (state == ST_RECV_REQ) ||
                      (state == ST_RECV_GAP);
    assign wdClear  = (stateNext != state);

    divider_host_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uWatchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wdClear),
        .enable (wdEnable),
        .expired(wdExpired)
    );

    // Next-state and next-value logic for all registered state and outputs.
    always_comb begin
        stateNext     = state;
        byteCountNext = byteCount;
        txShiftNext   = txShift;
        rxShiftNext   = rxShift;
        dataInNext    = DataIn;
        quotientNext  = quotient;
        remainderNext = remainder;
        errorNext     = error;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    stateNext     = ST_SEND_REQ;
                    txShiftNext   = {dividend, divisor};
                    byteCountNext = '0;
                    errorNext     = 1'b0;
                    dataInNext    = dividend[WIDTH-1 -: 8];
                end
            end
            ST_SEND_REQ: begin
                if (ReadyToAccept) begin
                    stateNext     = ST_SEND_GAP;
                    byteCountNext = byteCount + CNT_W'(1);
                end
            end
            ST_SEND_GAP: begin
                if (!ReadyToAccept) begin
                    if (byteCount == CNT_W'(NBYTES)) begin
                        byteCountNext = '0;
                        stateNext     = ST_WAIT_FULL;
                    end else begin
                        txShiftNext = txShift << 8;
                        dataInNext  = txShift[SHIFT_W-9 -: 8];
                        stateNext   = ST_SEND_REQ;
                    end
                end
            end
            ST_WAIT_FULL: begin
                if (OutBuffFull) begin
                    stateNext = ST_RECV_REQ;
                end
            end
            ST_RECV_REQ: begin
                if (Valid) begin
                    rxShiftNext   = {rxShift[SHIFT_W-9:0], DataOut};
                    byteCountNext = byteCount + CNT_W'(1);
                    stateNext     = ST_RECV_GAP;
                end
            end
            ST_RECV_GAP: begin
                if (!Valid) begin
                    if (byteCount == CNT_W'(NBYTES)) begin
                        quotientNext  = rxShift[SHIFT_W-1 -: WIDTH];
                        remainderNext = rxShift[WIDTH-1:0];
                        stateNext     = ST_RESP;
                    end else begin
                        stateNext = ST_WAIT_FULL;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase

        // Watchdog overrides any divider-side progress in the same cycle.
        if (wdExpired) begin
            stateNext     = ST_RESP;
            errorNext     = 1'b1;
            quotientNext  = '0;
            remainderNext = '0;
        end
    end

    // State and output registers; handshake strobes follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            byteCount   <= '0;
            txShift     <= '0;
            rxShift     <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            error       <= 1'b0;
            StartData   <= 1'b0;
            ReceiveData <= 1'b0;
            DataIn      <= '0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            state       <= stateNext;
            byteCount   <= byteCountNext;
            txShift     <= txShiftNext;
            rxShift     <= rxShiftNext;
            req_ready   <= (stateNext == ST_IDLE);
            rsp_valid   <= (stateNext == ST_RESP);
            error       <= errorNext;
            StartData   <= (stateNext == ST_SEND_REQ);
            ReceiveData <= (stateNext == ST_RECV_REQ);
            DataIn      <= dataInNext;
            quotient    <= quotientNext;
            remainder   <= remainderNext;
        end
    end

endmodule

// File: tb/tb_divider_host_port.sv
// Directed testbench for divider_host_port with a behavioral divider responder.
module tb_divider_host_port;

    localparam int unsigned WIDTH = 16;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // Main instance (default watchdog)
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             error;
    logic             StartData;
    logic [7:0]       DataIn;
    logic             ReadyToAccept = 1'b0;
    logic             OutBuffFull = 1'b0;
    logic             ReceiveData;
    logic             Valid = 1'b0;
    logic [7:0]       DataOut = '0;

    // Short-watchdog instance with a divider that never accepts
    logic             reqValid2 = 1'b0;
    logic             reqReady2;
    logic [WIDTH-1:0] dividend2 = '0;
    logic [WIDTH-1:0] divisor2 = '0;
    logic             rspValid2;
    logic             rspReady2 = 1'b0;
    logic [WIDTH-1:0] quotient2;
    logic [WIDTH-1:0] remainder2;
    logic             error2;
    logic             startData2;
    logic [7:0]       dataIn2;
    logic             receiveData2;

    int checks = 0;
    int errors = 0;

    divider_host_port #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .dividend(dividend), .divisor(divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .quotient(quotient), .remainder(remainder), .error(error),
        .StartData(StartData), .DataIn(DataIn), .ReadyToAccept(ReadyToAccept),
        .OutBuffFull(OutBuffFull), .ReceiveData(ReceiveData),
        .Valid(Valid), .DataOut(DataOut)
    );

    divider_host_port #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(16)) dutTo (
        .clk(clk), .reset(reset),
        .req_valid(reqValid2), .req_ready(reqReady2),
        .dividend(dividend2), .divisor(divisor2),
        .rsp_valid(rspValid2), .rsp_ready(rspReady2),
        .quotient(quotient2), .remainder(remainder2), .error(error2),
        .StartData(startData2), .DataIn(dataIn2), .ReadyToAccept(1'b0),
        .OutBuffFull(1'b0), .ReceiveData(receiveData2),
        .Valid(1'b0), .DataOut(8'h00)
    );

    initial forever #5 clk = ~clk;

    // Behavioral divider responder, stepped on the falling edge
    localparam int R_IN = 0, R_ACK = 1, R_OUTWAIT = 2, R_FULL = 3, R_VALID = 4;
    int         rs = R_IN;
    int         dly = 0;
    int         inCnt = 0;
    int         outCnt = 0;
    logic [7:0] inBytes [NB];
    logic [7:0] outBytes [NB];
    bit         validPulse = 1'b0;
    int         fullExtra = 0;
    bit         holdAck2 = 1'b0;
    int         overlapErrs = 0;
    logic [15:0] mA, mD, mQ, mR;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            rs = R_IN; dly = 0; inCnt = 0; outCnt = 0;
            ReadyToAccept = 1'b0; OutBuffFull = 1'b0; Valid = 1'b0; DataOut = '0;
        end else begin
            case (rs)
                R_IN: if (StartData) begin
                    if (dly == 0) begin
                        inBytes[inCnt] = DataIn;
                        inCnt++;
                        ReadyToAccept = 1'b1;
                        dly = int'($urandom_range(5, 0));
                        rs = R_ACK;
                    end else dly--;
                end
                R_ACK: if (!StartData && !(holdAck2 && inCnt == 2)) begin
                    if (dly == 0) begin
                        ReadyToAccept = 1'b0;
                        dly = int'($urandom_range(5, 0));
                        if (inCnt == NB) begin
                            mA = {inBytes[0], inBytes[1]};
                            mD = {inBytes[2], inBytes[3]};
                            mQ = (mD == 0) ? 16'hFFFF : mA / mD;
                            mR = (mD == 0) ? mA : mA % mD;
                            outBytes[0] = mQ[15:8]; outBytes[1] = mQ[7:0];
                            outBytes[2] = mR[15:8]; outBytes[3] = mR[7:0];
                            inCnt = 0; outCnt = 0;
                            dly = dly + fullExtra;
                            rs = R_OUTWAIT;
                        end else rs = R_IN;
                    end else dly--;
                end
                R_OUTWAIT: begin
                    if (ReceiveData) overlapErrs++;
                    if (dly == 0) begin
                        OutBuffFull = 1'b1;
                        dly = int'($urandom_range(5, 0));
                        rs = R_FULL;
                    end else dly--;
                end
                R_FULL: if (ReceiveData) begin
                    if (dly == 0) begin
                        Valid = 1'b1;
                        DataOut = outBytes[outCnt];
                        outCnt++;
                        OutBuffFull = 1'b0;
                        rs = R_VALID;
                    end else dly--;
                end
                R_VALID: if (validPulse || !ReceiveData) begin
                    Valid = 1'b0;
                    if (outCnt == NB) begin
                        dly = int'($urandom_range(5, 0));
                        rs = R_IN;
                    end else begin
                        dly = int'($urandom_range(5, 0)) + fullExtra;
                        rs = R_OUTWAIT;
                    end
                end
                default: rs = R_IN;
            endcase
        end
    end

    // Waits for req_ready, then offers one request for a single cycle.
    task automatic sendReq(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_accept: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic waitRsp();
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_wait: rsp_valid=%b required 1 within 2000 cycles", rsp_valid);
        end
    endtask

    task automatic takeRsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b error=%b required 1 0 0",
                     req_ready, rsp_valid, error);
        end
        checks++;
        if (StartData !== 1'b0 || ReceiveData !== 1'b0 || DataIn !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus: StartData=%b ReceiveData=%b DataIn=%h required 0 0 00",
                     StartData, ReceiveData, DataIn);
        end
        checks++;
        if (quotient !== 16'h0000 || remainder !== 16'h0000) begin
            errors++;
            $display("FAIL reset_result: q=%h r=%h required 0000 0000", quotient, remainder);
        end
    endtask

    task automatic test_basic();
        logic [7:0] expBytes [NB];
        expBytes[0] = 8'h56; expBytes[1] = 8'h9D; expBytes[2] = 8'h05; expBytes[3] = 8'h85;
        sendReq(16'h569D, 16'h0585);
        checks++;
        if (StartData !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_latency: StartData=%b req_ready=%b required 1 0", StartData, req_ready);
        end
        waitRsp();
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (inBytes[i] !== expBytes[i]) begin
                errors++;
                $display("FAIL byte_order[%0d]: DataIn=%h required %h", i, inBytes[i], expBytes[i]);
            end
        end
        checks++;
        if (quotient !== 16'h000F || remainder !== 16'h03D2 || error !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: q=%h r=%h err=%b required 000F 03D2 0",
                     quotient, remainder, error);
        end
        takeRsp();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_taken: req_ready=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_pulse_valid();
        validPulse = 1'b1; fullExtra = 20; overlapErrs = 0;
        sendReq(16'h1234, 16'h0100);
        waitRsp();
        checks++;
        if (quotient !== 16'h0012 || remainder !== 16'h0034 || error !== 1'b0) begin
            errors++;
            $display("FAIL pulse_result: q=%h r=%h err=%b required 0012 0034 0",
                     quotient, remainder, error);
        end
        checks++;
        if (overlapErrs !== 0) begin
            errors++;
            $display("FAIL pulse_overlap: ReceiveData high in gap %0d times required 0", overlapErrs);
        end
        takeRsp();
        validPulse = 1'b0; fullExtra = 0;
    endtask

    task automatic test_rsp_hold();
        int bad = 0;
        sendReq(16'h00FF, 16'h0010);
        waitRsp();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || quotient !== 16'h000F || remainder !== 16'h000F ||
                req_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rsp_hold: %0d unstable cycles (q=%h r=%h req_ready=%b) required 0",
                     bad, quotient, remainder, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        takeRsp();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: req_ready=%b required 1", req_ready);
        end
        sendReq(16'h0064, 16'h0007);
        waitRsp();
        checks++;
        if (quotient !== 16'h000E || remainder !== 16'h0002 || error !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: q=%h r=%h err=%b required 000E 0002 0",
                     quotient, remainder, error);
        end
        takeRsp();
    endtask

    task automatic test_timeout();
        int n = 0;
        int high = 0;
        reqValid2 = 1'b1; dividend2 = 16'h1234; divisor2 = 16'h0056;
        @(negedge clk);
        reqValid2 = 1'b0;
        while (startData2 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        while (startData2 === 1'b1 && high < 100) begin high++; @(negedge clk); end
        checks++;
        if (high !== 16) begin
            errors++;
            $display("FAIL timeout_len: StartData high %0d cycles required 16", high);
        end
        checks++;
        if (rspValid2 !== 1'b1 || error2 !== 1'b1 || startData2 !== 1'b0 || receiveData2 !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rsp: rsp_valid=%b error=%b StartData=%b ReceiveData=%b required 1 1 0 0",
                     rspValid2, error2, startData2, receiveData2);
        end
        checks++;
        if (quotient2 !== 16'h0000 || remainder2 !== 16'h0000) begin
            errors++;
            $display("FAIL timeout_result: q=%h r=%h required 0000 0000", quotient2, remainder2);
        end
        rspReady2 = 1'b1;
        @(negedge clk);
        rspReady2 = 1'b0;
        checks++;
        if (reqReady2 !== 1'b1 || rspValid2 !== 1'b0) begin
            errors++;
            $display("FAIL timeout_taken: req_ready=%b rsp_valid=%b required 1 0", reqReady2, rspValid2);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        holdAck2 = 1'b1;
        sendReq(16'h5555, 16'h0033);
        while (!(inCnt == 2 && StartData === 1'b0 && ReadyToAccept === 1'b1) && n < 200) begin
            @(negedge clk); n++;
        end
        checks++;
        if (inCnt != 2 || StartData !== 1'b0) begin
            errors++;
            $display("FAIL midreset_reach: bytes=%0d StartData=%b required 2 0", inCnt, StartData);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || error !== 1'b0 || StartData !== 1'b0 ||
            ReceiveData !== 1'b0 || DataIn !== 8'h00 || quotient !== 16'h0000 || remainder !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_outputs: rr=%b rv=%b err=%b sd=%b rd=%b di=%h q=%h r=%h required 1 0 0 0 0 00 0000 0000",
                     req_ready, rsp_valid, error, StartData, ReceiveData, DataIn, quotient, remainder);
        end
        @(negedge clk);
        reset = 1'b0;
        holdAck2 = 1'b0;
        @(negedge clk);
        sendReq(16'h0100, 16'h0010);
        waitRsp();
        checks++;
        if (quotient !== 16'h0010 || remainder !== 16'h0000 || error !== 1'b0) begin
            errors++;
            $display("FAIL midreset_fresh: q=%h r=%h err=%b required 0010 0000 0", quotient, remainder, error);
        end
        takeRsp();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pulse_valid();
        test_rsp_hold();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: bench still running at time %0t required finished", $time);
        $fatal(1);
    end

endmodule

// File: doc/divider_host_port.md
# divider_host_port

Host-side initiator for the restoring divider's byte-serial bus interface. Accepts a parallel dividend/divisor request, serializes it into the divider's byte-wide input handshake (StartData/DataIn/ReadyToAccept), then drains the divider's output buffer (OutBuffFull/ReceiveData/Valid/DataOut) and returns a parallel quotient/remainder response. Sits between system logic and the divider, replacing the bench-driven byte protocol in integrated builds.

## Interface
- WIDTH, 16, operand width in bits; a multiple of 8, at least 8. NBYTES = 2*WIDTH/8 bytes each way.
- TIMEOUT_CYCLES, 1024, watchdog limit per divider-side wait state; at least 4.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- dividend  in  WIDTH  sampled on req handshake.
- divisor  in  WIDTH  sampled on req handshake.
- rsp_valid  out  1  response held until taken.
- rsp_ready  in  1  consumer accepts response.
- quotient  out  WIDTH  result; stable while rsp_valid.
- remainder  out  WIDTH  result; stable while rsp_valid.
- error  out  1  watchdog expired; qualifies rsp_valid.
- StartData  out  1  byte offered to divider.
- DataIn  out  8  byte to divider.
- ReadyToAccept  in  1  divider captured the byte.
- OutBuffFull  in  1  divider holds a result byte.
- ReceiveData  out  1  request for the next result byte.
- Valid  in  1  DataOut carries a result byte.
- DataOut  in  8  result byte.

## Operation
- Input byte order: dividend MS byte first, then remaining dividend bytes, then divisor MS byte first. Output order: quotient MS byte first, then remainder MS byte first.
- States: IDLE, SEND_REQ, SEND_GAP, WAIT_FULL, RECV_REQ, RECV_GAP, RESP.
- IDLE: req_ready=1. On req_valid: latch {dividend, divisor} into a 2*WIDTH shift register, clear byte count and error, go to SEND_REQ.
- SEND_REQ: StartData=1, DataIn=current byte. On ReadyToAccept=1: go to SEND_GAP, increment count.
- SEND_GAP: StartData=0. On ReadyToAccept=0: if count==NBYTES, clear count and go to WAIT_FULL; else shift to the next byte and go to SEND_REQ.
- WAIT_FULL: on OutBuffFull=1, go to RECV_REQ.
- RECV_REQ: ReceiveData=1. On Valid=1: shift DataOut into the result register, increment count, go to RECV_GAP.
- RECV_GAP: ReceiveData=0. On Valid=0: if count==NBYTES, go to RESP; else go to WAIT_FULL.
- RESP: rsp_valid=1. On rsp_ready=1: go to IDLE.
- Watchdog: a counter clears on every state change. If it reaches TIMEOUT_CYCLES in SEND_REQ, SEND_GAP, WAIT_FULL, RECV_REQ or RECV_GAP:
  - set error=1, drive StartData and ReceiveData to 0;
  - go to RESP with quotient and remainder forced to 0.
- Divisor zero is not special-cased: the bytes are forwarded and the divider's returned bytes are passed through.

## Timing
- All outputs are registered. Reset values:
  - req_ready=1 (IDLE);
  - rsp_valid, error, StartData, ReceiveData = 0;
  - DataIn, quotient, remainder = 0.
- Request accepted at edge N → StartData=1 from edge N+1.
- ReadyToAccept sampled high at edge M → StartData=0 from edge M+1.
- A byte takes at least 2 cycles; the next StartData rises no earlier than 1 cycle after ReadyToAccept is sampled low.
- Result bytes: ReceiveData rises 1 cycle after OutBuffFull is sampled high. It falls 1 cycle after Valid is sampled high. DataOut is captured on that same edge where Valid is sampled high.
- A one-cycle Valid pulse is sufficient. Valid held high stalls the block in RECV_GAP.
- rsp_valid rises 1 cycle after the last Valid falls. Back-to-back: a response taken at edge K gives req_ready=1 at edge K+1.
- Reset mid-operation: IDLE at the next edge, all outputs at reset values; the divider shares the reset.

## Structure
- Package divider_host_pkg holds:
  - the state enum;
  - localparam/function for NBYTES;
  - default WIDTH and TIMEOUT_CYCLES.
- Sub-module divider_host_watchdog: the counter with clear, enable and expired flag, parameterized by TIMEOUT_CYCLES.
- Everything else lives in one FSM plus two shift registers (send, receive).

## Test plan
- A behavioral divider responder, with variable ReadyToAccept/Valid delays of 0-5 cycles, is shared across all scenarios.
- Request dividend=0x569D, divisor=0x0585:
  - DataIn sequence 0x56, 0x9D, 0x05, 0x85;
  - response quotient=0x000F, remainder=0x03D2, error=0.
- Responder returns Valid as a single-cycle pulse, with OutBuffFull delayed by 20 cycles: all 4 bytes are captured and ReceiveData never overlaps the gap.
- rsp_ready held low for 10 cycles: rsp_valid, quotient and remainder stay stable; req_ready stays 0 until the response is taken.
- Responder never asserts ReadyToAccept, TIMEOUT_CYCLES=16:
  - exactly 16 cycles after StartData rises, StartData=0;
  - rsp_valid=1, error=1, quotient and remainder = 0.
- Reset asserted while in SEND_GAP after byte 2: the next cycle shows all outputs at reset values. A fresh request with dividend=0x0100, divisor=0x0010 completes with quotient=0x0010, remainder=0x0000.
